punch_judge: RTL and testbench
==============================

// Module: punch_judge
// PURPOSE
//  Game-round judge downstream of the random target generator. Requests a target,
//  lights the matching zombie LED, then judges the player's punch within a time window.
//  Keeps score and lives and stops the game when lives reach zero.
//  Consumes 1..3 target codes plus debounced single-cycle button pulses; drives LEDs and status.
// PARAMETERS
//  WINDOW_CYCLES  50_000_000  punch window per target, in clk cycles (0.8 s at 62.5 MHz)
//  RESULT_CYCLES  12_500_000  hold time of the hit/miss display before the next round
//  LIVES          3           lives at game start, 1..7
//  SCORE_W        8           score width; score saturates at 2**SCORE_W-1
// PORTS
//  clk           in   1        system clock
//  rst           in   1        asynchronous reset, active-low
//  start         in   1        1-cycle pulse: begin game (honoured only in IDLE/OVER)
//  target_valid  in   1        1-cycle pulse: target is valid
//  target        in   2        zombie index 1..3; 0 = no target
//  btn           in   3        debounced 1-cycle press pulses; btn[i] punches zombie i+1
//  req_next      out  1        1-cycle pulse: request a new target
//  led           out  4        led[3:1] one-hot target, led[0] hit flag
//  score         out  SCORE_W  hits so far
//  lives         out  3        remaining lives
//  hit           out  1        1-cycle pulse on correct punch
//  miss          out  1        1-cycle pulse on wrong punch or timeout
//  game_over     out  1        high in OVER
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; led=0, score=0, lives=LIVES, req_next=hit=miss=game_over=0.
//  All outputs are registered. A decision made at cycle N is visible at N+1.
//  IDLE: outputs at reset values. start -> REQ.
//  REQ: req_next=1 for exactly one cycle -> WAIT_TGT.
//  WAIT_TGT: btn ignored. On target_valid with target in 1..3: latch it, load window
//    counter with WINDOW_CYCLES-1 -> ACTIVE. On target_valid with target=0 -> REQ (retry).
//    Without target_valid, wait indefinitely.
//  ACTIVE: led = {onehot(target),1'b0}. The counter decrements each cycle. Each cycle, in priority order:
//    - btn == onehot(target): hit, score+1 (saturating; no wrap).
//    - btn != 0 otherwise (wrong button, or several at once including the right one): miss.
//    - counter == 0 and btn == 0: timeout miss.
//    A press on the same cycle the counter reaches 0 is judged as a press, not a timeout.
//    Exactly WINDOW_CYCLES ACTIVE cycles before timeout. On any miss, lives-1 (never below 0).
//    Any decision -> RESULT, loading the result counter with RESULT_CYCLES-1.
//  RESULT: lasts RESULT_CYCLES cycles. After a hit, led=4'b0001. After a miss, led=0.
//    btn and target_valid are ignored. At end: lives==0 -> OVER, else REQ.
//  OVER: game_over=1, led=4'b1111; score and lives hold. start -> clear score,
//    lives=LIVES, game_over=0 -> REQ.
//  start outside IDLE/OVER is ignored. target_valid outside WAIT_TGT is ignored.
//  Reset asserted mid-round aborts immediately to IDLE, including mid-pulse.
// TESTING  (WINDOW_CYCLES=8, RESULT_CYCLES=4, LIVES=3, SCORE_W=4)
//  1 rst low, then start -> req_next one cycle; target_valid target=2 -> led=4'b0100;
//    btn=3'b010 on ACTIVE cycle 3 -> hit next cycle, score=1, led=4'b0001 for 4 cycles, req_next.
//  2 target=1, no press -> miss exactly 8 cycles after entering ACTIVE, lives=2, led=0.
//  3 target=3, btn=3'b110 -> miss (multi-press), lives decrements; btn=3'b001 on target=3 -> miss.
//  4 Press of the correct btn on the cycle the counter is 0 -> hit, not miss.
//  5 Three misses -> game_over=1, led=4'b1111, start mid-RESULT ignored;
//    start in OVER -> score=0, lives=3, req_next.
//  6 target_valid target=0 -> req_next re-pulses. 16 hits -> score saturates at 15.
//    rst low during ACTIVE -> IDLE and all reset values.

Source files
------------

// File: rtl/punch_judge.sv
// punch_judge: game-round judge. Requests a target from the random generator,
// lights the matching zombie LED, judges the player's punch inside a time
// window, and keeps score and lives until the game is over.
module punch_judge #(
  parameter int WINDOW_CYCLES = 50_000_000,
  parameter int RESULT_CYCLES = 12_500_000,
  parameter int LIVES         = 3,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               target_valid,
  input  logic [1:0]         target,
  input  logic [2:0]         btn,
  output logic               req_next,
  output logic [3:0]         led,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               hit,
  output logic               miss,
  output logic               game_over
);

  // One down-counter serves both the punch window and the result hold.
  localparam int CNT_MAX = (WINDOW_CYCLES > RESULT_CYCLES) ? WINDOW_CYCLES : RESULT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   WIN_LOAD   = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RES_LOAD   = CNT_W'(RESULT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ZERO = SCORE_W'(0);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_TGT = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_RESULT   = 3'd4,
    ST_OVER     = 3'd5
  } state_t;

  // Zombie index 1..3 to one-hot button/LED pattern; 0 maps to no bits.
  function automatic logic [2:0] tgt_onehot(input logic [1:0] t);
    logic [2:0] oh;
    case (t)
      2'd1:    oh = 3'b001;
      2'd2:    oh = 3'b010;
      2'd3:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [1:0]         tgt_r, tgt_s;
  logic               res_hit_r, res_hit_s;
  logic [SCORE_W-1:0] score_r, score_s;
  logic [2:0]         lives_r, lives_s;
  logic               req_r, req_s;
  logic [3:0]         led_r, led_s;
  logic               hit_r, hit_s;
  logic               miss_r, miss_s;
  logic               over_r, over_s;

  // Next-state, counters, score/lives and the next value of every output.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    tgt_s     = tgt_r;
    res_hit_s = res_hit_r;
    score_s   = score_r;
    lives_s   = lives_r;
    hit_s     = 1'b0;
    miss_s    = 1'b0;
    led_s     = 4'b0000;
    req_s     = 1'b0;
    over_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_s = ST_WAIT_TGT;
      end
      ST_WAIT_TGT: begin
        if (target_valid) begin
          if (target != 2'd0) begin
            tgt_s   = target;
            cnt_s   = WIN_LOAD;
            state_s = ST_ACTIVE;
          end else begin
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_WAIT_TGT;
        end
      end
      ST_ACTIVE: begin
        // A press always outranks the timeout, even on the last window cycle.
        if (btn == tgt_onehot(tgt_r)) begin
          hit_s     = 1'b1;
          res_hit_s = 1'b1;
          score_s   = (score_r == SCORE_MAX) ? SCORE_MAX : score_r + SCORE_ONE;
          cnt_s     = RES_LOAD;
          state_s   = ST_RESULT;
        end else if ((btn != 3'b000) || (cnt_r == CNT_ZERO)) begin
          miss_s    = 1'b1;
          res_hit_s = 1'b0;
          lives_s   = (lives_r == 3'd0) ? 3'd0 : lives_r - 3'd1;
          cnt_s     = RES_LOAD;
          state_s   = ST_RESULT;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_RESULT: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = (lives_r == 3'd0) ? ST_OVER : ST_REQ;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_OVER: begin
        if (start) begin
          score_s = SCORE_ZERO;
          lives_s = LIVES_INIT;
          state_s = ST_REQ;
        end else begin
          state_s = ST_OVER;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Outputs follow the state being entered so they line up with it.
    req_s  = (state_s == ST_REQ);
    over_s = (state_s == ST_OVER);
    case (state_s)
      ST_ACTIVE: led_s = {tgt_onehot(tgt_s), 1'b0};
      ST_RESULT: led_s = {3'b000, res_hit_s};
      ST_OVER:   led_s = 4'b1111;
      default:   led_s = 4'b0000;
    endcase
  end

  // State, counter, game bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      tgt_r     <= 2'd0;
      res_hit_r <= 1'b0;
      score_r   <= SCORE_ZERO;
      lives_r   <= LIVES_INIT;
      req_r     <= 1'b0;
      led_r     <= 4'b0000;
      hit_r     <= 1'b0;
      miss_r    <= 1'b0;
      over_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      tgt_r     <= tgt_s;
      res_hit_r <= res_hit_s;
      score_r   <= score_s;
      lives_r   <= lives_s;
      req_r     <= req_s;
      led_r     <= led_s;
      hit_r     <= hit_s;
      miss_r    <= miss_s;
      over_r    <= over_s;
    end
  end

  assign req_next  = req_r;
  assign led       = led_r;
  assign score     = score_r;
  assign lives     = lives_r;
  assign hit       = hit_r;
  assign miss      = miss_r;
  assign game_over = over_r;

endmodule

// File: tb/tb_punch_judge.sv
// tb_punch_judge: directed game scenarios with a scoreboard of expected
// round results (hit/miss, score, lives) pushed when a punch is planned.
module tb_punch_judge;
  localparam int W  = 8;
  localparam int R  = 4;
  localparam int L  = 3;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          target_valid = 1'b0;
  logic [1:0]    target = 2'd0;
  logic [2:0]    btn = 3'b000;
  logic          req_next;
  logic [3:0]    led;
  logic [SW-1:0] score;
  logic [2:0]    lives;
  logic          hit;
  logic          miss;
  logic          game_over;

  int total = 0;
  int bad   = 0;
  int m_score = 0;
  int m_lives = L;

  typedef struct {
    bit is_hit;
    int score;
    int lives;
  } exp_t;
  exp_t sb_q[$];

  punch_judge #(
    .WINDOW_CYCLES(W),
    .RESULT_CYCLES(R),
    .LIVES(L),
    .SCORE_W(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .target_valid(target_valid),
    .target(target),
    .btn(btn),
    .req_next(req_next),
    .led(led),
    .score(score),
    .lives(lives),
    .hit(hit),
    .miss(miss),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Leaves REQ, hands over a nonzero target, checks the target LED.
  task automatic give_target(input logic [1:0] t);
    logic [3:0] led_exp;
    tick();
    target_valid = 1'b1;
    target = t;
    tick();
    target_valid = 1'b0;
    target = 2'd0;
    led_exp = 4'b0001 << t;
    chk("led_target", 32'(led), 32'(led_exp));
  endtask

  task automatic push_hit();
    if (m_score < 15) m_score++;
    else m_score = 15;
    sb_q.push_back('{is_hit: 1'b1, score: m_score, lives: m_lives});
  endtask

  task automatic push_miss();
    if (m_lives > 0) m_lives--;
    else m_lives = 0;
    sb_q.push_back('{is_hit: 1'b0, score: m_score, lives: m_lives});
  endtask

  // Waits wait_cycles ACTIVE cycles, then presses b for one cycle.
  task automatic press(input logic [2:0] b, input int wait_cycles);
    repeat (wait_cycles) tick();
    btn = b;
    tick();
    btn = 3'b000;
  endtask

  // Waits for the round decision, compares it with the scoreboard, then
  // follows the RESULT phase to its end (REQ or OVER).
  task automatic judge(input bit poke_start, output int lat);
    exp_t e;
    logic [3:0] led_exp;
    lat = 0;
    while (!(hit === 1'b1 || miss === 1'b1) && lat < 30) begin
      tick();
      lat++;
    end
    chk("result_seen", 32'(hit | miss), 32'd1);
    e = '{is_hit: 1'b0, score: -1, lives: -1};
    if (sb_q.size() != 0) e = sb_q.pop_front();
    chk("hit_flag", 32'(hit), 32'(e.is_hit));
    chk("miss_flag", 32'(miss), 32'(!e.is_hit));
    chk("score", 32'(score), 32'(e.score));
    chk("lives", 32'(lives), 32'(e.lives));
    led_exp = e.is_hit ? 4'b0001 : 4'b0000;
    chk("result_led", 32'(led), 32'(led_exp));
    for (int i = 1; i < R; i++) begin
      if (poke_start && i == 1) start = 1'b1;
      tick();
      start = 1'b0;
      chk("result_hold_led", 32'(led), 32'(led_exp));
      chk("pulse_width", 32'(hit | miss), 32'd0);
    end
    tick();
    if (e.lives != 0) begin
      chk("next_req", 32'(req_next), 32'd1);
    end else begin
      chk("game_over", 32'(game_over), 32'd1);
      chk("over_led", 32'(led), 32'hF);
      chk("over_score", 32'(score), 32'(m_score));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=time limit expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [1:0] t;
    logic [2:0] b;

    // Reset state
    @(negedge clk);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_req", 32'(req_next), 32'd0);
    chk("rst_hit_miss", 32'({hit, miss}), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_req", 32'(req_next), 32'd0);

    // Start -> single req_next pulse; buttons ignored while waiting
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_req", 32'(req_next), 32'd1);
    tick();
    chk("req_one_cycle", 32'(req_next), 32'd0);
    btn = 3'b010;
    tick();
    btn = 3'b000;
    chk("wait_btn_ignored", 32'({hit, miss}), 32'd0);
    chk("wait_led", 32'(led), 32'd0);

    // Hit on ACTIVE cycle 3
    give_target(2'd2);
    push_hit();
    press(3'b010, 2);
    judge(1'b0, lat);

    // Correct press on the cycle the counter reaches 0 is a hit
    give_target(2'd1);
    push_hit();
    press(3'b001, 7);
    judge(1'b0, lat);

    // Timeout: miss exactly W cycles after entering ACTIVE
    give_target(2'd1);
    push_miss();
    judge(1'b0, lat);
    chk("timeout_latency", 32'(lat), 32'(W));

    // Multi-press including the right one -> miss
    give_target(2'd3);
    push_miss();
    press(3'b110, 0);
    judge(1'b0, lat);

    // Wrong button -> last life lost; start during RESULT ignored
    give_target(2'd3);
    push_miss();
    press(3'b001, 1);
    judge(1'b1, lat);
    tick();
    chk("over_hold", 32'(game_over), 32'd1);
    chk("over_lives", 32'(lives), 32'd0);

    // Start in OVER clears the game
    start = 1'b1;
    tick();
    start = 1'b0;
    m_score = 0;
    m_lives = L;
    chk("restart_req", 32'(req_next), 32'd1);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_lives", 32'(lives), 32'd3);
    chk("restart_over", 32'(game_over), 32'd0);

    // target 0 -> retry request
    tick();
    target_valid = 1'b1;
    target = 2'd0;
    tick();
    target_valid = 1'b0;
    chk("retry_req", 32'(req_next), 32'd1);

    // 16 hits -> score saturates
    for (int i = 0; i < 16; i++) begin
      t = 2'((i % 3) + 1);
      b = 3'b001 << (t - 2'd1);
      give_target(t);
      push_hit();
      press(b, i % 4);
      judge(1'b0, lat);
    end
    chk("score_saturated", 32'(score), 32'd15);

    // Reset in the middle of ACTIVE
    give_target(2'd2);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_led", 32'(led), 32'd0);
    chk("midrst_score", 32'(score), 32'd0);
    chk("midrst_lives", 32'(lives), 32'd3);
    chk("midrst_flags", 32'({req_next, hit, miss, game_over}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_idle", 32'({req_next, led}), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_start", 32'(req_next), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
